// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter in front of a single-port SRAM.
// One access per cycle; read data returns one cycle after acceptance.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration on
// contention; otherwise r0 has fixed priority.
// Reset is synchronous active-low; outputs are also forced to their reset
// values while rst_n is low so the reset cycle itself is quiet.
module sram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_rsp_valid,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           gnt_cnt0,
    output logic [15:0]           gnt_cnt1
);

    logic                  last_gnt_q, last_gnt_d;
    logic                  rsp0_q, rsp0_d;
    logic                  rsp1_q, rsp1_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [15:0]           gnt_cnt0_q, gnt_cnt0_d;
    logic [15:0]           gnt_cnt1_q, gnt_cnt1_d;
    logic                  gnt0, gnt1, acc, sel_we;

    // Arbitration: pick at most one winner among the valid requesters.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (r0_valid && r1_valid) begin
`ifdef SRAM_ARB_RR_EN
                if (last_gnt_q) gnt0 = 1'b1;
                else            gnt1 = 1'b1;
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = r0_valid;
                gnt1 = r1_valid;
            end
        end
    end

    // SRAM command and handshake outputs, driven from the winner.
    always_comb begin
        acc       = gnt0 | gnt1;
        sel_we    = gnt1 ? r1_we : r0_we;
        r0_ready  = gnt0;
        r1_ready  = gnt1;
        mem_re    = acc & ~sel_we;
        mem_we    = acc & sel_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (acc) begin
            mem_addr  = gnt1 ? r1_addr : r0_addr;
            mem_wdata = gnt1 ? r1_wdata : r0_wdata;
        end
    end

    // Next-state: response tracking, read-data hold, last grant, counters.
    always_comb begin
        last_gnt_d = acc ? gnt1 : last_gnt_q;
        rsp0_d     = gnt0 & ~r0_we;
        rsp1_d     = gnt1 & ~r1_we;
        rdata_d    = (rsp0_q | rsp1_q) ? mem_rdata : rdata_q;
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        if (gnt0 && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
        if (gnt1 && gnt_cnt1_q != 16'hFFFF) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            rdata_q    <= '0;
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rsp0_q     <= rsp0_d;
            rsp1_q     <= rsp1_d;
            rdata_q    <= rdata_d;
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    // Response outputs; rsp_rdata passes SRAM data through in the response
    // cycle and otherwise holds the last delivered word.
    always_comb begin
        r0_rsp_valid = rst_n & rsp0_q;
        r1_rsp_valid = rst_n & rsp1_q;
        rsp_rdata    = '0;
        if (rst_n) rsp_rdata = (rsp0_q | rsp1_q) ? mem_rdata : rdata_q;
        gnt_cnt0     = rst_n ? gnt_cnt0_q : '0;
        gnt_cnt1     = rst_n ? gnt_cnt1_q : '0;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by
// random traffic, checked cycle by cycle against a behavioural model.
module tb_sram_arbiter;
    localparam int DW = 32;
    localparam int AW = 4;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          r0_valid, r0_ready, r0_we, r0_rsp_valid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r1_valid, r1_ready, r1_we, r1_rsp_valid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_re, mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [15:0]   gnt_cnt0, gnt_cnt1;

    sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid),
        .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    // SRAM behaviour seen by the arbiter (environment, not the reference).
    logic [DW-1:0] sram [16] = '{default: '0};
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int            m_last = 1;
    int            m_cnt [2] = '{0, 0};
    logic [DW-1:0] m_mem [16] = '{default: '0};
    int            m_pend_who = -1;
    logic [DW-1:0] m_pend_data = '0;
    logic [DW-1:0] m_hold = '0;

    // Observations captured in the most recent step, for directed checks.
    logic          s_r0_ready, s_r1_ready, s_r0_rsp, s_r1_rsp;
    logic [DW-1:0] s_rdata;
    logic [15:0]   s_cnt0, s_cnt1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst,
                        input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int            win;
        logic          wwe;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        @(negedge clk);
        rst_n = rst;
        r0_valid = v0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
        #1;
        win = -1;
        if (rst) begin
            if (v0 && v1)  win = RR ? ((m_last == 0) ? 1 : 0) : 0;
            else if (v0)   win = 0;
            else if (v1)   win = 1;
        end
        wwe = (win == 1) ? w1 : w0;
        wa  = (win == 1) ? a1 : a0;
        wd  = (win == 1) ? d1 : d0;
        chk("r0_ready", 32'(r0_ready), 32'(win == 0));
        chk("r1_ready", 32'(r1_ready), 32'(win == 1));
        chk("mem_re", 32'(mem_re), 32'(win >= 0 && !wwe));
        chk("mem_we", 32'(mem_we), 32'(win >= 0 && wwe));
        chk("re_we_excl", 32'(mem_re & mem_we), 32'(0));
        if (win >= 0) chk("mem_addr", 32'(mem_addr), 32'(wa));
        if (win >= 0 && wwe) chk("mem_wdata", mem_wdata, wd);
        chk("r0_rsp_valid", 32'(r0_rsp_valid), 32'(rst && m_pend_who == 0));
        chk("r1_rsp_valid", 32'(r1_rsp_valid), 32'(rst && m_pend_who == 1));
        chk("rsp_rdata", rsp_rdata, !rst ? '0 : ((m_pend_who >= 0) ? m_pend_data : m_hold));
        chk("gnt_cnt0", 32'(gnt_cnt0), rst ? 32'(m_cnt[0]) : 32'(0));
        chk("gnt_cnt1", 32'(gnt_cnt1), rst ? 32'(m_cnt[1]) : 32'(0));
        s_r0_ready = r0_ready; s_r1_ready = r1_ready;
        s_r0_rsp = r0_rsp_valid; s_r1_rsp = r1_rsp_valid;
        s_rdata = rsp_rdata; s_cnt0 = gnt_cnt0; s_cnt1 = gnt_cnt1;
        @(posedge clk);
        if (!rst) begin
            m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
            m_pend_who = -1; m_hold = '0;
        end else begin
            if (m_pend_who >= 0) m_hold = m_pend_data;
            m_pend_who = -1;
            if (win >= 0) begin
                if (wwe) m_mem[wa] = wd;
                else begin
                    m_pend_who  = win;
                    m_pend_data = m_mem[wa];
                end
                if (m_cnt[win] < 65535) m_cnt[win]++;
                m_last = win;
            end
        end
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    int            g [4];
    logic [DW-1:0] pat [2];

    initial begin
        rst_n = 1'b0;
        r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;

        // Reset state, then first cycle out of reset is idle.
        idle(1'b0);
        idle(1'b0);
        chk("rst_r0_rsp", 32'(s_r0_rsp), 32'(0));
        chk("rst_cnt0", 32'(s_cnt0), 32'(0));
        chk("rst_rdata", s_rdata, 32'h0);
        idle(1'b1);

        // Write then read-back on r0.
        step(1'b1, 1'b1, 1'b1, 4'd3, 32'hA5A5_0001, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0, 4'd3, '0, 1'b0, 1'b0, '0, '0);
        idle(1'b1);
        chk("wr_rd_rsp0", 32'(s_r0_rsp), 32'(1));
        chk("wr_rd_rsp1", 32'(s_r1_rsp), 32'(0));
        chk("wr_rd_data", s_rdata, 32'hA5A5_0001);

        // Contention: both reading addr 1 / 2 for 4 cycles from fresh reset.
        pat[0] = 32'h1111_0001;
        pat[1] = 32'h2222_0002;
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd1, pat[0]);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd2, pat[1]);
        idle(1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1'b1, 1'b1, 1'b0, 4'd1, '0, 1'b1, 1'b0, 4'd2, '0);
            else       idle(1'b1);
            if (i < 4) g[i] = s_r1_ready ? 1 : (s_r0_ready ? 0 : -1);
            if (i > 0) begin
                chk("cont_rsp0", 32'(s_r0_rsp), 32'(g[i-1] == 0));
                chk("cont_rsp1", 32'(s_r1_rsp), 32'(g[i-1] == 1));
                chk("cont_data", s_rdata, (g[i-1] == 1) ? pat[1] : pat[0]);
            end
        end
        for (int i = 0; i < 4; i++)
            chk("cont_grant", 32'(g[i]), RR ? 32'(i % 2) : 32'(0));
        chk("cont_cnt0", 32'(s_cnt0), RR ? 32'(2) : 32'(4));
        chk("cont_cnt1", 32'(s_cnt1), RR ? 32'(2) : 32'(0));

        // Read accepted just before reset must not respond.
        idle(1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd5, '0);
        idle(1'b0);
        chk("rstrd_rsp1", 32'(s_r1_rsp), 32'(0));
        chk("rstrd_cnt1", 32'(s_cnt1), 32'(0));
        chk("rstrd_data", s_rdata, 32'h0);
        idle(1'b1);
        chk("rstrd_rsp1_after", 32'(s_r1_rsp), 32'(0));

        // Counter saturation from 0xFFFE.
        #1 force dut.gnt_cnt0_q = 16'hFFFE;
        #1 release dut.gnt_cnt0_q;
        m_cnt[0] = 16'hFFFE;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 4'(i), '0, 1'b0, 1'b0, '0, '0);
        idle(1'b1);
        chk("sat_cnt0", 32'(s_cnt0), 32'h0000_FFFF);

        // Random traffic against the model.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(63) != 0),
                 1'($urandom), 1'($urandom), 4'($urandom), $urandom,
                 1'($urandom), 1'($urandom), 4'($urandom), $urandom);
        end
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
